io_input_port: RTL and testbench
================================

# io_input_port

Responder side of the processor's input handshake. The processor executes an IO input instruction, raises its request (LED bank all-ones) and waits for `trigger`. This block synchronizes and debounces the board switches and push button, and presents one switch word per button press on `in`. It raises `trigger` and holds it until the processor drops its request. It sits on the board top level between the pins and the processor's `in`/`trigger`/`led` ports.

## Interface
- DATA_W, 10, width of switch word / `in`
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a new button level (≥1)
- CNT_W, 16, debounce counter width (must hold DEBOUNCE_CYCLES)

- clock  in  1  system clock, same net as processor clock; this block uses rising edges
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- request  in  1  processor input request (processor `led[0]`); 1 = waiting for input
- switches  in  DATA_W  raw asynchronous switch pins
- button  in  1  raw asynchronous push button, 1 = pressed
- trigger  out  1  to processor `trigger`; 1 = `in` valid
- in  out  DATA_W  to processor `in`; latched switch word
- armed  out  1  1 while waiting for a press against an active request
- press_count  out  8  number of accepted inputs, wraps 255→0

## Operation
- Synchronizers: 2-flop on `button` and on each `switches` bit. `sw_s`/`btn_s` are the second-stage outputs.
- Debouncer:
  - `btn_db` resets to 0.
  - Counter clears whenever `btn_s == btn_db`.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, `btn_db <= btn_s` and the counter clears.
- `press` = one-cycle pulse on a `btn_db` 0→1 transition.
- FSM states: IDLE, ARMED, PRESENT, RELEASE.
  - IDLE: trigger=0. `request==1` → ARMED. A `press` in IDLE is discarded (no queuing).
  - ARMED: armed=1, trigger=0.
    - `request==0` → IDLE (processor reset or abort).
    - Else on `press`: `in <= sw_s`, `press_count++`, → PRESENT.
    - If `request` falls and `press` occurs in the same cycle, `request` wins: → IDLE, nothing latched.
  - PRESENT: trigger=1, `in` frozen. `request==0` → RELEASE. No timeout; trigger holds indefinitely.
  - RELEASE: trigger=0, `in` frozen. `btn_db==0` → IDLE. This enforces one press = one input. A new request arriving here is served only after button release.
- `in` changes only on the ARMED→PRESENT transition. It keeps its last value otherwise.
- Reset (any time, any state):
  - state=IDLE, trigger=0, in=0, press_count=0, btn_db=0, counter=0, synchronizers=0.
  - A button held through reset release is seen as a fresh press after debounce; it is accepted only if ARMED.

## Timing
- Button-to-`btn_db` latency: 2 (sync) + DEBOUNCE_CYCLES cycles of stable level.
- `press` to `trigger` high and `in` valid: same rising edge (1 cycle from the `btn_db` edge). `in` and `trigger` change together.
- Sampling: the processor samples on falling edges. `in` is stable from the rise of `trigger` until IDLE→ARMED of the next request. `trigger` is held until `request` is seen low, so it is present across at least one processor falling edge.
- `request` low to `trigger` low: 1 cycle.
- Minimum `trigger` low time between inputs: until button release debounced (≥ DEBOUNCE_CYCLES + 2).
- `armed`, `trigger` and `press_count` are registered outputs; no combinational path from inputs.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
- **Basic handshake:** reset low then high; switches=10'h2A5; request=1; press button 10 cycles → armed=1, then trigger=1 with in=10'h2A5, press_count=1. Drop request → trigger=0 next cycle. Release button → IDLE.
- **Bounce rejection:** request=1; button toggles every 2 cycles for 20 cycles, then stays 1 → exactly one trigger, press_count=1. Bounce on release produces no second input.
- **Press without request:** request=0; press and release → trigger stays 0, in unchanged, press_count=0. Then request=1 → armed=1, no trigger until a new press.
- **Held button across requests:** complete one input and keep the button held. Raise request again → stays in RELEASE/IDLE, trigger=0. Release then press with switches=10'h001 → in=10'h001, press_count=2.
- **Abort and simultaneous events:** in ARMED, drop request on the same cycle as `press` → IDLE, in unchanged, press_count unchanged.
- **Wrap and reset:** 256 accepted inputs → press_count=0. Assert reset while in PRESENT → trigger=0, in=0, press_count=0 immediately (before the next clock).

Source files
------------

// File: rtl/io_input_port.sv
// ----------------------------------------------------------------------------
// io_input_port
//
// Responder side of the processor's input handshake. Board switches and the
// push button are synchronized, the button is debounced, and one switch word
// is presented per accepted press while the processor holds its request.
//
// Ports
//   i_clock        system clock (rising edge), shared with the processor
//   i_reset        asynchronous active-low reset
//   i_request      processor input request, 1 = waiting for input
//   i_switches     raw asynchronous switch pins
//   i_button       raw asynchronous push button, 1 = pressed
//   o_trigger      1 = o_in valid, held until i_request is seen low
//   o_in           latched switch word
//   o_armed        1 while waiting for a press against an active request
//   o_press_count  accepted inputs, wraps 255 -> 0
//
// State table
//   S_IDLE    | no request being served; presses are discarded
//   S_ARMED   | request active, waiting for a debounced press
//   S_PRESENT | o_in valid, trigger held until the request drops
//   S_RELEASE | request dropped, waiting for the button to be released
// ----------------------------------------------------------------------------
module io_input_port #(
    parameter int DATA_W          = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_request,
    input  logic [DATA_W-1:0] i_switches,
    input  logic              i_button,
    output logic              o_trigger,
    output logic [DATA_W-1:0] o_in,
    output logic              o_armed,
    output logic [7:0]        o_press_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_PRESENT = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Counter value on which the DEBOUNCE_CYCLES-th mismatching sample lands.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              r_btn_meta;
    logic              r_btn_s;
    logic [DATA_W-1:0] r_sw_meta;
    logic [DATA_W-1:0] r_sw_s;
    logic [CNT_W-1:0]  r_db_cnt;
    logic              r_btn_db;
    logic              r_btn_db_q;
    state_t            r_state;
    state_t            w_next;
    logic              w_press;
    logic              w_latch;
    logic              r_trigger;
    logic              r_armed;
    logic [DATA_W-1:0] r_in;
    logic [7:0]        r_press_count;

    // Two-flop synchronizers on every asynchronous pin.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
        end else begin
            r_btn_meta <= i_button;
            r_btn_s    <= r_btn_meta;
            r_sw_meta  <= i_switches;
            r_sw_s     <= r_sw_meta;
        end
    end

    // Debouncer: the counter only runs while the synchronized level differs
    // from the accepted level, so any bounce back restarts the qualification.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
        end else begin
            r_btn_db_q <= r_btn_db;
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= '0;
                r_btn_db <= r_btn_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_btn_db & ~r_btn_db_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A falling request takes priority over a simultaneous press in ARMED.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_request) begin
                    w_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!i_request) begin
                    w_next = S_IDLE;
                end else if (w_press) begin
                    w_next  = S_PRESENT;
                    w_latch = 1'b1;
                end
            end
            S_PRESENT: begin
                if (!i_request) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!r_btn_db) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the same
    // edge as the state and o_in, with no path from the input pins.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_trigger     <= 1'b0;
            r_armed       <= 1'b0;
            r_in          <= '0;
            r_press_count <= 8'd0;
        end else begin
            r_trigger <= (w_next == S_PRESENT);
            r_armed   <= (w_next == S_ARMED);
            if (w_latch) begin
                r_in          <= r_sw_s;
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    assign o_trigger     = r_trigger;
    assign o_armed       = r_armed;
    assign o_in          = r_in;
    assign o_press_count = r_press_count;

endmodule

// File: tb/tb_io_input_port.sv
module tb_io_input_port;

    localparam int DW        = 10;
    localparam int D         = 4;
    // Button edge to trigger: 2 sync stages, D stable samples, 1 FSM edge.
    localparam int PRESS_LAT = 2 + D + 1;
    // Button release until the handshake is back in IDLE, plus one margin.
    localparam int SETTLE    = 2 + D + 2;

    logic          clk;
    logic          rst_n;
    logic          request;
    logic [DW-1:0] switches;
    logic          button;
    logic          trigger;
    logic [DW-1:0] in_w;
    logic          armed;
    logic [7:0]    press_count;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model: the word and count the processor should have seen.
    logic [DW-1:0] exp_in    = '0;
    logic [7:0]    exp_count = 8'd0;

    io_input_port #(
        .DATA_W(DW),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_request(request),
        .i_switches(switches),
        .i_button(button),
        .o_trigger(trigger),
        .o_in(in_w),
        .o_armed(armed),
        .o_press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trigger(input int max_cyc, output int cyc);
        cyc = 0;
        while (trigger !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; request = 1'b0; button = 1'b0; switches = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (trigger !== 1'b0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: trigger=%b armed=%b want 0 0", trigger, armed);
        end
        n_checks++;
        if (in_w !== 10'h000 || press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: in=%h count=%0d want 000 0", in_w, press_count);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (armed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_armed: got %b want 0", armed);
        end
    endtask

    task automatic test_basic();
        int cyc;
        switches = 10'h2A5;
        request  = 1'b1;
        tick();
        n_checks++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_armed: got %b want 1", armed);
        end
        button = 1'b1;
        wait_trigger(20, cyc);
        exp_in = 10'h2A5;
        exp_count++;
        n_checks++;
        if (trigger !== 1'b1 || cyc != PRESS_LAT) begin
            n_fail++;
            $display("FAIL basic_latency: trigger=%b cycles=%0d want 1 %0d", trigger, cyc, PRESS_LAT);
        end
        n_checks++;
        if (in_w !== exp_in || press_count !== exp_count || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_data: in=%h count=%0d armed=%b want %h %0d 0",
                     in_w, press_count, armed, exp_in, exp_count);
        end
        repeat (10 - PRESS_LAT) tick();
        n_checks++;
        if (trigger !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: trigger=%b want 1", trigger);
        end
        request = 1'b0;
        tick();
        n_checks++;
        if (trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drop: trigger=%b want 0", trigger);
        end
        button = 1'b0;
        repeat (SETTLE) tick();
        n_checks++;
        if (in_w !== exp_in || trigger !== 1'b0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: in=%h trigger=%b armed=%b want %h 0 0", in_w, trigger, armed, exp_in);
        end
    endtask

    task automatic test_bounce();
        int   rises;
        logic prev;
        rises    = 0;
        prev     = trigger;
        switches = DW'($urandom);
        request  = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            button = ~i[1];
            tick();
            if (trigger === 1'b1 && prev !== 1'b1) rises++;
            prev = trigger;
        end
        button = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trigger === 1'b1 && prev !== 1'b1) rises++;
            prev = trigger;
        end
        exp_in = switches;
        exp_count++;
        n_checks++;
        if (rises != 1 || press_count !== exp_count || in_w !== exp_in) begin
            n_fail++;
            $display("FAIL bounce_press: rises=%0d count=%0d in=%h want 1 %0d %h",
                     rises, press_count, in_w, exp_count, exp_in);
        end
        request = 1'b0;
        tick();
        request = 1'b1;
        rises = 0;
        prev  = trigger;
        for (int i = 0; i < 20; i++) begin
            button = i[1];
            tick();
            if (trigger === 1'b1 && prev !== 1'b1) rises++;
            prev = trigger;
        end
        button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (trigger === 1'b1 && prev !== 1'b1) rises++;
            prev = trigger;
        end
        n_checks++;
        if (rises != 0 || press_count !== exp_count || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_release: rises=%0d count=%0d armed=%b want 0 %0d 1",
                     rises, press_count, armed, exp_count);
        end
        request = 1'b0;
        tick();
    endtask

    task automatic test_no_request();
        bit seen;
        seen     = 1'b0;
        request  = 1'b0;
        switches = DW'($urandom);
        button   = 1'b1;
        repeat (10) begin tick(); if (trigger !== 1'b0) seen = 1'b1; end
        button = 1'b0;
        repeat (10) begin tick(); if (trigger !== 1'b0) seen = 1'b1; end
        n_checks++;
        if (seen || in_w !== exp_in || press_count !== exp_count) begin
            n_fail++;
            $display("FAIL noreq_press: trig_seen=%b in=%h count=%0d want 0 %h %0d",
                     seen, in_w, press_count, exp_in, exp_count);
        end
        request = 1'b1;
        tick();
        n_checks++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL noreq_armed: got %b want 1", armed);
        end
        repeat (10) begin tick(); if (trigger !== 1'b0 || armed !== 1'b1) seen = 1'b1; end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL noreq_wait: trigger=%b armed=%b want 0 1", trigger, armed);
        end
        request = 1'b0;
        tick();
    endtask

    task automatic test_held();
        int cyc;
        bit bad;
        bad      = 1'b0;
        switches = DW'($urandom);
        request  = 1'b1;
        tick();
        button = 1'b1;
        wait_trigger(20, cyc);
        exp_in = switches;
        exp_count++;
        n_checks++;
        if (trigger !== 1'b1 || in_w !== exp_in || press_count !== exp_count) begin
            n_fail++;
            $display("FAIL held_first: trigger=%b in=%h count=%0d want 1 %h %0d",
                     trigger, in_w, press_count, exp_in, exp_count);
        end
        request = 1'b0;
        tick();
        request = 1'b1;
        repeat (10) begin tick(); if (trigger !== 1'b0 || armed !== 1'b0) bad = 1'b1; end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL held_blocked: trigger=%b armed=%b want 0 0", trigger, armed);
        end
        switches = 10'h001;
        button   = 1'b0;
        repeat (SETTLE + 1) tick();
        n_checks++;
        if (armed !== 1'b1 || trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL held_rearm: armed=%b trigger=%b want 1 0", armed, trigger);
        end
        button = 1'b1;
        wait_trigger(20, cyc);
        exp_in = 10'h001;
        exp_count++;
        n_checks++;
        if (trigger !== 1'b1 || cyc != PRESS_LAT || in_w !== exp_in || press_count !== exp_count) begin
            n_fail++;
            $display("FAIL held_second: trigger=%b cycles=%0d in=%h count=%0d want 1 %0d %h %0d",
                     trigger, cyc, in_w, press_count, PRESS_LAT, exp_in, exp_count);
        end
        request = 1'b0;
        tick();
        button = 1'b0;
        repeat (SETTLE) tick();
    endtask

    task automatic test_abort();
        bit bad;
        bad      = 1'b0;
        switches = DW'($urandom);
        request  = 1'b1;
        tick();
        button = 1'b1;
        repeat (PRESS_LAT - 1) tick();
        n_checks++;
        if (armed !== 1'b1 || trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre: armed=%b trigger=%b want 1 0", armed, trigger);
        end
        // The debounced press is visible this cycle; drop the request with it.
        request = 1'b0;
        tick();
        n_checks++;
        if (trigger !== 1'b0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_edge: trigger=%b armed=%b want 0 0", trigger, armed);
        end
        repeat (5) begin tick(); if (trigger !== 1'b0) bad = 1'b1; end
        button = 1'b0;
        repeat (SETTLE) begin tick(); if (trigger !== 1'b0) bad = 1'b1; end
        n_checks++;
        if (bad || in_w !== exp_in || press_count !== exp_count) begin
            n_fail++;
            $display("FAIL abort_data: trig_seen=%b in=%h count=%0d want 0 %h %0d",
                     bad, in_w, press_count, exp_in, exp_count);
        end
        request = 1'b1;
        tick();
        n_checks++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rearm: armed=%b want 1", armed);
        end
        request = 1'b0;
        tick();
    endtask

    task automatic test_random_wrap();
        int n;
        int cyc;
        int hold;
        n = 256 - int'(exp_count);
        for (int k = 0; k < n; k++) begin
            switches = DW'($urandom);
            request  = 1'b1;
            tick();
            button = 1'b1;
            wait_trigger(20, cyc);
            exp_in = switches;
            exp_count++;
            n_checks++;
            if (trigger !== 1'b1 || in_w !== exp_in || press_count !== exp_count) begin
                n_fail++;
                $display("FAIL rand_accept[%0d]: trigger=%b in=%h count=%0d want 1 %h %0d",
                         k, trigger, in_w, press_count, exp_in, exp_count);
            end
            hold = $urandom_range(0, 4);
            repeat (hold) begin
                switches = DW'($urandom);
                tick();
            end
            n_checks++;
            if (trigger !== 1'b1 || in_w !== exp_in) begin
                n_fail++;
                $display("FAIL rand_frozen[%0d]: trigger=%b in=%h want 1 %h", k, trigger, in_w, exp_in);
            end
            request = 1'b0;
            tick();
            n_checks++;
            if (trigger !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_drop[%0d]: trigger=%b want 0", k, trigger);
            end
            button = 1'b0;
            repeat (SETTLE) tick();
        end
        n_checks++;
        if (press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 0", press_count);
        end
    endtask

    task automatic test_reset_present();
        int cyc;
        bit bad;
        bad      = 1'b0;
        switches = DW'($urandom) | 10'h200;
        request  = 1'b1;
        tick();
        button = 1'b1;
        wait_trigger(20, cyc);
        exp_in = switches;
        exp_count++;
        n_checks++;
        if (trigger !== 1'b1 || press_count !== exp_count) begin
            n_fail++;
            $display("FAIL rstp_present: trigger=%b count=%0d want 1 %0d", trigger, press_count, exp_count);
        end
        rst_n = 1'b0;
        #1;
        exp_in    = '0;
        exp_count = 8'd0;
        n_checks++;
        if (trigger !== 1'b0 || in_w !== exp_in || press_count !== exp_count) begin
            n_fail++;
            $display("FAIL rstp_async: trigger=%b in=%h count=%0d want 0 000 0", trigger, in_w, press_count);
        end
        request = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (15) begin tick(); if (trigger !== 1'b0) bad = 1'b1; end
        n_checks++;
        if (bad || press_count !== exp_count || in_w !== exp_in) begin
            n_fail++;
            $display("FAIL rstp_held_idle: trig_seen=%b count=%0d in=%h want 0 0 000", bad, press_count, in_w);
        end
        button = 1'b0;
        repeat (SETTLE) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_no_request();
        test_held();
        test_abort();
        test_random_wrap();
        test_reset_present();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
